// File: rtl/fc_ich_mac.sv
// Fully-connected MAC: ICH_T-wide multiply, adder tree and accumulate over ICH_B beats per neuron.
// Optional FC_MAC_RELU_EN clamps negative results to zero in the output register.
module fc_ich_mac #(
  parameter int unsigned ICH_T  = 10,
  parameter int unsigned ICH_B  = 40,
  parameter int unsigned I_F_BW = 8,
  parameter int unsigned W_BW   = 8,
  parameter int unsigned B_BW   = 16,
  parameter int unsigned ACC_BW = 32
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     i_run,
  input  logic [B_BW-1:0]          i_bias,
  input  logic                     i_in_valid,
  input  logic [ICH_T*I_F_BW-1:0]  i_infmap,
  input  logic [ICH_T*W_BW-1:0]    i_weight,
  output logic                     o_idle,
  output logic                     o_run,
  output logic                     o_en_err,
  output logic                     o_in_err,
  output logic                     o_ot_valid,
  output logic                     o_ot_done,
  output logic [ACC_BW-1:0]        o_ot_acc
);

  localparam int unsigned PW   = I_F_BW + W_BW + 1;
  localparam int unsigned CntW = (ICH_B > 1) ? $clog2(ICH_B) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ICH_B - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      drain_q, drain_d;
  logic signed [PW-1:0]      prod_q [ICH_T];
  logic signed [PW-1:0]      prod_d [ICH_T];
  logic signed [ACC_BW-1:0]  sum_q, sum_d;
  logic signed [ACC_BW-1:0]  acc_q, acc_d;
  logic [ACC_BW-1:0]         result_q, result_d;
  logic                      v1_q, v2_q;
  logic                      valid_q;
  logic                      en_err_q, in_err_q;
  logic                      run_acc, beat_acc;

  // A new neuron may start from idle or directly out of the done cycle.
  assign run_acc  = i_run && ((state_q == StIdle) || (state_q == StDone));
  assign beat_acc = i_in_valid && (state_q == StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = 1'b0;
    unique case (state_q)
      StIdle:  if (i_run) state_d = StRun;
      StRun:   if (beat_acc && (cnt_q == CntLast)) state_d = StDrain;
      StDrain: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = StDone;
      end
      StDone:  state_d = i_run ? StRun : StIdle;
    endcase
    if (run_acc) begin
      cnt_d = '0;
    end else if (beat_acc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < ICH_T; k++) begin
      prod_d[k] = PW'($signed({1'b0, i_infmap[k*I_F_BW +: I_F_BW]}))
                * PW'($signed(i_weight[k*W_BW +: W_BW]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < ICH_T; k++) begin
      sum_d = sum_d + ACC_BW'(prod_q[k]);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (run_acc) begin
      acc_d = ACC_BW'($signed(i_bias));
    end else if (v2_q) begin
      acc_d = acc_q + sum_q;
    end
  end

  always_comb begin
    result_d = result_q;
    if (state_q == StDone) begin
`ifdef FC_MAC_RELU_EN
      result_d = acc_q[ACC_BW-1] ? '0 : acc_q;
`else
      result_d = acc_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
      for (int unsigned k = 0; k < ICH_T; k++) prod_q[k] <= '0;
      sum_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      valid_q  <= 1'b0;
      en_err_q <= 1'b0;
      in_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      if (beat_acc) begin
        for (int unsigned k = 0; k < ICH_T; k++) prod_q[k] <= prod_d[k];
      end
      sum_q    <= sum_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      v1_q     <= beat_acc;
      v2_q     <= v1_q;
      valid_q  <= (state_q == StDone);
      if (i_run && ((state_q == StRun) || (state_q == StDrain))) en_err_q <= 1'b1;
      if (i_in_valid && (state_q != StRun)) in_err_q <= 1'b1;
    end
  end

  assign o_idle     = (state_q == StIdle);
  assign o_run      = (state_q != StIdle);
  assign o_en_err   = en_err_q;
  assign o_in_err   = in_err_q;
  assign o_ot_valid = valid_q;
  assign o_ot_done  = valid_q;
  assign o_ot_acc   = result_q;

endmodule

// File: tb/tb_fc_ich_mac.sv
// Directed self-checking bench for fc_ich_mac (default parameters, 10 lanes x 40 beats).
module tb_fc_ich_mac;

  localparam int ICH_T = 10;

  logic              clk = 1'b0;
  logic              areset;
  logic              i_run;
  logic [15:0]       i_bias;
  logic              i_in_valid;
  logic [ICH_T*8-1:0] i_infmap;
  logic [ICH_T*8-1:0] i_weight;
  logic              o_idle, o_run, o_en_err, o_in_err, o_ot_valid, o_ot_done;
  logic [31:0]       o_ot_acc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int done_miss = 0;
  int last_cyc = 0;
  logic [31:0] res_q[$];

  fc_ich_mac dut (
    .clk        (clk),
    .areset     (areset),
    .i_run      (i_run),
    .i_bias     (i_bias),
    .i_in_valid (i_in_valid),
    .i_infmap   (i_infmap),
    .i_weight   (i_weight),
    .o_idle     (o_idle),
    .o_run      (o_run),
    .o_en_err   (o_en_err),
    .o_in_err   (o_in_err),
    .o_ot_valid (o_ot_valid),
    .o_ot_done  (o_ot_done),
    .o_ot_acc   (o_ot_acc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_ot_valid === 1'b1) begin
      strobe_cnt++;
      strobe_cyc = cyc;
      res_q.push_back(o_ot_acc);
      if (o_ot_done !== 1'b1) done_miss++;
    end else if (o_ot_done === 1'b1) begin
      done_miss++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    res_q.delete();
  endtask

  task automatic start(input logic [15:0] bias);
    i_run  = 1'b1;
    i_bias = bias;
    tick();
    i_run  = 1'b0;
  endtask

  // Drives n beats with `gap` idle cycles after each; optionally pulses i_run with beat run_at.
  task automatic send_beats(input int n, input int gap, input logic [7:0] inf,
                            input logic [7:0] wt, input int run_at);
    for (int i = 0; i < n; i++) begin
      i_in_valid = 1'b1;
      i_infmap   = {ICH_T{inf}};
      i_weight   = {ICH_T{wt}};
      if (i == run_at) i_run = 1'b1;
      last_cyc = cyc;
      tick();
      i_in_valid = 1'b0;
      i_run      = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", o_idle); end
    checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b expected 0", o_run); end
    checks++; if (o_en_err !== 1'b0 || o_in_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got en=%b in=%b expected 0 0", o_en_err, o_in_err);
    end
    checks++; if (o_ot_valid !== 1'b0 || o_ot_done !== 1'b0) begin
      errors++; $display("FAIL reset_strobe: got v=%b d=%b expected 0 0", o_ot_valid, o_ot_done);
    end
    checks++; if (o_ot_acc !== 32'd0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", $signed(o_ot_acc)); end
  endtask

  task automatic test_basic();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    start(16'd0);
    checks++; if (o_run !== 1'b1 || o_idle !== 1'b0) begin
      errors++; $display("FAIL basic_running: got run=%b idle=%b expected 1 0", o_run, o_idle);
    end
    send_beats(40, 0, 8'd1, 8'd1, -1);
    repeat (8) tick();
    checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL basic_strobes: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (o_ot_acc !== 32'd400) begin errors++; $display("FAIL basic_acc: got %0d expected 400", $signed(o_ot_acc)); end
    checks++; if (strobe_cyc !== last_cyc + 4) begin
      errors++; $display("FAIL basic_latency: got %0d expected 4", strobe_cyc - last_cyc);
    end
    checks++; if (done_miss !== 0) begin errors++; $display("FAIL basic_done: got %0d miscoincident expected 0", done_miss); end
    checks++; if (o_idle !== 1'b1 || o_en_err !== 1'b0 || o_in_err !== 1'b0) begin
      errors++; $display("FAIL basic_end: got idle=%b en=%b in=%b expected 1 0 0", o_idle, o_en_err, o_in_err);
    end
  endtask

  task automatic test_negative();
    logic [31:0] exp;
`ifdef FC_MAC_RELU_EN
    exp = 32'd0;
`else
    exp = -32'sd13088768;
`endif
    do_reset();
    start(16'h8000);
    send_beats(40, 0, 8'hFF, 8'h80, -1);
    repeat (8) tick();
    checks++; if (o_ot_acc !== exp) begin
      errors++; $display("FAIL negative_acc: got %0d expected %0d", $signed(o_ot_acc), $signed(exp));
    end
    checks++; if (strobe_cyc !== last_cyc + 4) begin
      errors++; $display("FAIL negative_latency: got %0d expected 4", strobe_cyc - last_cyc);
    end
  endtask

  task automatic test_bubbles();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    start(16'd0);
    send_beats(40, 1, 8'd1, 8'd1, -1);
    repeat (8) tick();
    checks++; if (o_ot_acc !== 32'd400) begin errors++; $display("FAIL bubbles_acc: got %0d expected 400", $signed(o_ot_acc)); end
    checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL bubbles_strobes: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (o_in_err !== 1'b0) begin errors++; $display("FAIL bubbles_in_err: got %b expected 0", o_in_err); end
    checks++; if (strobe_cyc !== last_cyc + 4) begin
      errors++; $display("FAIL bubbles_latency: got %0d expected 4", strobe_cyc - last_cyc);
    end
  endtask

  task automatic test_errors();
    do_reset();
    start(16'd0);
    send_beats(5, 0, 8'd1, 8'd1, 4);
    checks++; if (o_en_err !== 1'b1) begin errors++; $display("FAIL err_en: got %b expected 1", o_en_err); end
    checks++; if (o_in_err !== 1'b0) begin errors++; $display("FAIL err_in_early: got %b expected 0", o_in_err); end
    send_beats(35, 0, 8'd1, 8'd1, -1);
    // Now in drain: this beat must be dropped and flagged.
    i_in_valid = 1'b1;
    i_infmap   = {ICH_T{8'd9}};
    tick();
    i_in_valid = 1'b0;
    repeat (8) tick();
    checks++; if (o_in_err !== 1'b1) begin errors++; $display("FAIL err_in: got %b expected 1", o_in_err); end
    checks++; if (o_ot_acc !== 32'd400) begin errors++; $display("FAIL err_acc: got %0d expected 400", $signed(o_ot_acc)); end
    checks++; if (o_en_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", o_en_err); end
    // Run and beat together in idle: run accepted, beat dropped.
    do_reset();
    i_in_valid = 1'b1;
    i_infmap   = {ICH_T{8'd50}};
    i_weight   = {ICH_T{8'd1}};
    start(16'd0);
    i_in_valid = 1'b0;
    send_beats(40, 0, 8'd1, 8'd1, -1);
    repeat (8) tick();
    checks++; if (o_ot_acc !== 32'd400 || o_in_err !== 1'b1 || o_en_err !== 1'b0) begin
      errors++; $display("FAIL idle_both: got acc=%0d in=%b en=%b expected 400 1 0",
                         $signed(o_ot_acc), o_in_err, o_en_err);
    end
  endtask

  task automatic test_abort();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    start(16'd0);
    send_beats(20, 0, 8'd1, 8'd1, -1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checks++; if (o_idle !== 1'b1 || o_ot_acc !== 32'd0) begin
      errors++; $display("FAIL abort_state: got idle=%b acc=%0d expected 1 0", o_idle, $signed(o_ot_acc));
    end
    start(16'd7);
    send_beats(40, 0, 8'd1, 8'd1, -1);
    repeat (8) tick();
    checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL abort_strobes: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (o_ot_acc !== 32'd407) begin errors++; $display("FAIL abort_acc: got %0d expected 407", $signed(o_ot_acc)); end
  endtask

  task automatic test_back_to_back();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    start(16'd0);
    send_beats(40, 0, 8'd1, 8'd1, -1);
    tick();
    tick();
    checks++; if (o_run !== 1'b1 || o_idle !== 1'b0) begin
      errors++; $display("FAIL b2b_done_state: got run=%b idle=%b expected 1 0", o_run, o_idle);
    end
    start(16'd5);
    send_beats(40, 0, 8'd2, 8'd1, -1);
    repeat (8) tick();
    checks++; if (strobe_cnt !== s0 + 2 || res_q.size() != 2) begin
      errors++; $display("FAIL b2b_strobes: got %0d expected 2", strobe_cnt - s0);
    end else begin
      checks++; if (res_q[0] !== 32'd400) begin errors++; $display("FAIL b2b_first: got %0d expected 400", $signed(res_q[0])); end
      checks++; if (res_q[1] !== 32'd805) begin errors++; $display("FAIL b2b_second: got %0d expected 805", $signed(res_q[1])); end
    end
    checks++; if (o_en_err !== 1'b0 || o_in_err !== 1'b0) begin
      errors++; $display("FAIL b2b_err: got en=%b in=%b expected 0 0", o_en_err, o_in_err);
    end
  endtask

  initial begin
    areset     = 1'b1;
    i_run      = 1'b0;
    i_bias     = '0;
    i_in_valid = 1'b0;
    i_infmap   = '0;
    i_weight   = '0;
    test_reset();
    test_basic();
    test_negative();
    test_bubbles();
    test_errors();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_ich_mac.md
FC_ICH_MAC -- requirements
Module: fc_ich_mac

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ICH_T, 10, infmap/weight elements per input beat.
- ICH_B, 40, beats per output neuron.
- I_F_BW, 8, infmap element width, unsigned.
- W_BW, 8, weight element width, signed.
- B_BW, 16, bias width, signed.
- ACC_BW, 32, accumulator and result width, signed.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- areset, in, 1, reset: synchronous, active-high.
- i_run, in, 1, start-of-neuron pulse.
- i_bias, in, B_BW, bias; sampled with i_run.
- i_in_valid, in, 1, input beat valid.
- i_infmap, in, ICH_T*I_F_BW, element k at bits [k*I_F_BW +: I_F_BW].
- i_weight, in, ICH_T*W_BW, element k at bits [k*W_BW +: W_BW].
- o_idle, out, 1, high in S_IDLE.
- o_run, out, 1, high in S_RUN, S_DRAIN and S_DONE.
- o_en_err, out, 1, sticky: i_run received while busy.
- o_in_err, out, 1, sticky: i_in_valid received outside S_RUN.
- o_ot_valid, out, 1, one-cycle result strobe.
- o_ot_done, out, 1, one-cycle completion strobe, coincident with o_ot_valid.
- o_ot_acc, out, ACC_BW, signed neuron result.

Function
REQ-003 FSM states: S_IDLE, S_RUN, S_DRAIN, S_DONE.
- S_IDLE -> S_RUN on i_run.
- S_RUN -> S_DRAIN on the edge that samples the ICH_B-th accepted beat.
- S_DRAIN -> S_DONE after 2 cycles.
- S_DONE -> S_RUN if i_run, else S_IDLE.
REQ-004 On an accepted i_run, accumulator loads sign-extended i_bias and beat counter (width clog2(ICH_B)) clears.
REQ-005 A beat is accepted only when i_in_valid=1 in S_RUN; beats may arrive with arbitrary bubbles.
REQ-006 Pipeline stage 1 registers ICH_T products: zero-extended infmap times signed weight, each I_F_BW+W_BW+1 bits signed.
REQ-007 Stage 2 registers the signed sum of the ICH_T products.
REQ-008 Stage 3 adds that sum into the accumulator; all arithmetic is sign-extended to ACC_BW with no saturation (two's-complement wrap).
REQ-009 Result is registered into o_ot_acc; o_ot_valid and o_ot_done pulse exactly 4 cycles after the cycle presenting the final beat.
REQ-010 o_ot_acc holds its value until the next result or reset.
REQ-011 i_run in S_DONE starts the next neuron back-to-back with no error.
REQ-012 i_run in S_RUN or S_DRAIN is ignored, and o_en_err is set.
REQ-013 i_in_valid in S_IDLE, S_DRAIN or S_DONE is ignored, and o_in_err is set.
REQ-014 i_run and i_in_valid in the same S_IDLE cycle: run accepted, beat dropped, o_in_err set.
REQ-015 Sticky errors clear only on areset.

Reset
REQ-016 On areset: FSM to S_IDLE; counter, accumulator and pipeline registers to 0; o_idle=1; o_run=0; o_en_err=0; o_in_err=0; o_ot_valid=0; o_ot_done=0; o_ot_acc=0.
REQ-017 areset mid-operation abandons the neuron; no o_ot_valid is produced for it.

Configuration
REQ-018 Macro FC_MAC_RELU_EN.
- Defined: a negative final result is replaced by 0 in the o_ot_acc register.
- Undefined: the raw signed accumulator is output.
- Timing is identical in both cases.

Verification
REQ-019 bias=0, all infmap=1, all weights=1, 40 contiguous beats -> o_ot_acc=400; o_ot_valid 4 cycles after beat 40.
REQ-020 bias=-32768, infmap=255, weight=-128, 40 beats -> o_ot_acc=-13088768 with macro undefined; 0 with FC_MAC_RELU_EN.
REQ-021 Same stimulus as REQ-019 with one idle cycle between every beat -> o_ot_acc=400, one strobe, o_in_err=0.
REQ-022 i_run at beat 5, then i_in_valid during S_DRAIN -> o_en_err=1, o_in_err=1, o_ot_acc=400 unaffected.
REQ-023 areset at beat 20, then a fresh run of 40 beats with bias=7 -> exactly one strobe, o_ot_acc=407.
REQ-024 i_run in the S_DONE cycle for a second neuron -> both results produced with no error and no lost beats.
